cic_decim_iq: RTL



---
 rtl/cic_decim_iq_pkg.sv | 34 +++
 rtl/cic_decim_iq_integ.sv | 39 +++
 rtl/cic_decim_iq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cic_decim_iq_pkg.sv
// Shared state type and arithmetic helpers for the cic_decim_iq decimator.
package cic_pkg;

    // Wide enough to hold any shifted accumulator before clamping.
    localparam int unsigned SAT_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        COMB,
        OUT
    } cic_state_e;

    function automatic int unsigned cic_min_width(input int unsigned bits,
                                                  input int unsigned stages,
                                                  input int unsigned decim_bits);
        return bits + stages * decim_bits;
    endfunction

    function automatic logic signed [SAT_W-1:0] cic_sat(input logic signed [SAT_W-1:0] v,
                                                        input int unsigned out_bits);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) << (out_bits - 1)) - SAT_W'(1);
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/cic_decim_iq_integ.sv
// One channel of the STAGES-deep pipelined CIC integrator; wraps modulo 2^WIDTH.
module cic_integ_chain #(
    parameter int unsigned STAGES = 3,
    parameter int unsigned BITS   = 8,
    parameter int unsigned WIDTH  = 44
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic                    in_tick,
    input  logic signed [BITS-1:0]  x,
    output logic signed [WIDTH-1:0] y
);
    logic signed [WIDTH-1:0] acc_q [STAGES];
    logic signed [WIDTH-1:0] acc_d [STAGES];

    // Every stage adds the previous stage's pre-update value.
    always_comb begin
        acc_d = acc_q;
        if (in_tick) begin
            acc_d[0] = acc_q[0] + WIDTH'(x);
            for (int unsigned k = 1; k < STAGES; k++) begin
                acc_d[k] = acc_q[k] + acc_q[k-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            acc_q <= acc_d;
        end
    end

    assign y = acc_q[STAGES-1];

endmodule

// File: rtl/cic_decim_iq.sv
// Dual-channel (I/Q) CIC decimator: runtime ratio and shift, shared comb engine, sticky overrun.
// Optional feature macro CIC_ROUND_EN: round half up before the output shift.
module cic_decim_iq
    import cic_pkg::*;
#(
    parameter int unsigned STAGES     = 3,
    parameter int unsigned BITS       = 8,
    parameter int unsigned DECIM_BITS = 12,
    parameter int unsigned WIDTH      = 44,
    parameter int unsigned OUT_BITS   = 16,
    parameter int unsigned SHIFT_BITS = 6
) (
    input  logic                         CLK,
    input  logic                         RSTb,
    input  logic                         in_tick,
    input  logic signed [BITS-1:0]       x_i,
    input  logic signed [BITS-1:0]       x_q,
    input  logic        [DECIM_BITS-1:0] decim,
    input  logic        [SHIFT_BITS-1:0] shift,
    output logic signed [OUT_BITS-1:0]   y_i,
    output logic signed [OUT_BITS-1:0]   y_q,
    output logic                         out_tick,
    output logic                         overrun
);
    localparam int unsigned SW = (STAGES > 1) ? $clog2(STAGES) : 1;

    if (STAGES < 1 || STAGES > 6) begin : g_stages_chk
        $error("cic_decim_iq: STAGES must be in 1..6");
    end
    if (WIDTH < cic_min_width(BITS, STAGES, DECIM_BITS)) begin : g_width_chk
        $error("cic_decim_iq: WIDTH below BITS + STAGES*DECIM_BITS");
    end
    if (WIDTH + 1 > SAT_W) begin : g_sat_chk
        $error("cic_decim_iq: WIDTH too large for the saturation helper");
    end

    logic signed [WIDTH-1:0]    int_i, int_q;
    cic_state_e                 state_q, state_d;
    logic [SW-1:0]              s_q, s_d;
    logic [DECIM_BITS-1:0]      cnt_q, cnt_d, r_lat_q, r_lat_d, decim_eff;
    logic [SHIFT_BITS-1:0]      shift_lat_q, shift_lat_d;
    logic signed [WIDTH-1:0]    i_samp_q, i_samp_d, q_samp_q, q_samp_d;
    logic signed [WIDTH-1:0]    i_acc_q, i_acc_d, q_acc_q, q_acc_d;
    logic signed [WIDTH-1:0]    i_dly_q [STAGES];
    logic signed [WIDTH-1:0]    i_dly_d [STAGES];
    logic signed [WIDTH-1:0]    q_dly_q [STAGES];
    logic signed [WIDTH-1:0]    q_dly_d [STAGES];
    logic signed [OUT_BITS-1:0] y_i_q, y_i_d, y_q_q, y_q_d;
    logic                       req_q, req_d, out_tick_q, out_tick_d, overrun_q, overrun_d;
    logic                       wrap, busy;

    cic_integ_chain #(.STAGES(STAGES), .BITS(BITS), .WIDTH(WIDTH)) u_integ_i (
        .CLK(CLK), .RSTb(RSTb), .in_tick(in_tick), .x(x_i), .y(int_i)
    );
    cic_integ_chain #(.STAGES(STAGES), .BITS(BITS), .WIDTH(WIDTH)) u_integ_q (
        .CLK(CLK), .RSTb(RSTb), .in_tick(in_tick), .x(x_q), .y(int_q)
    );

    function automatic logic signed [OUT_BITS-1:0] scale(input logic signed [WIDTH-1:0] a,
                                                         input logic [SHIFT_BITS-1:0] sh);
        logic signed [WIDTH:0]   e;
        logic signed [SAT_W-1:0] w;
        e = (WIDTH+1)'(a);
`ifdef CIC_ROUND_EN
        if (sh != '0) begin
            e = e + ((WIDTH+1)'(1) << (sh - SHIFT_BITS'(1)));
        end
`endif
        e = e >>> sh;
        w = cic_sat(SAT_W'(e), OUT_BITS);
        return w[OUT_BITS-1:0];
    endfunction

    assign decim_eff = (decim < DECIM_BITS'(2)) ? DECIM_BITS'(2) : decim;

    always_comb begin
        wrap        = in_tick && (cnt_q == r_lat_q - DECIM_BITS'(1));
        // A request still waiting for the engine counts as busy too.
        busy        = (state_q != IDLE) || req_q;
        cnt_d       = cnt_q;
        r_lat_d     = r_lat_q;
        shift_lat_d = shift_lat_q;
        i_samp_d    = i_samp_q;
        q_samp_d    = q_samp_q;
        req_d       = req_q;
        overrun_d   = overrun_q;
        state_d     = state_q;
        s_d         = s_q;
        i_acc_d     = i_acc_q;
        q_acc_d     = q_acc_q;
        i_dly_d     = i_dly_q;
        q_dly_d     = q_dly_q;
        y_i_d       = y_i_q;
        y_q_d       = y_q_q;
        out_tick_d  = 1'b0;

        if (in_tick) begin
            cnt_d = wrap ? '0 : cnt_q + DECIM_BITS'(1);
        end
        if (wrap) begin
            r_lat_d     = decim_eff;
            shift_lat_d = shift;
            if (busy) begin
                overrun_d = 1'b1;
            end else begin
                i_samp_d = int_i;
                q_samp_d = int_q;
                req_d    = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (req_q) begin
                    req_d   = 1'b0;
                    i_acc_d = i_samp_q;
                    q_acc_d = q_samp_q;
                    s_d     = '0;
                    state_d = COMB;
                end
            end
            COMB: begin
                i_acc_d      = i_acc_q - i_dly_q[s_q];
                q_acc_d      = q_acc_q - q_dly_q[s_q];
                i_dly_d[s_q] = i_acc_q;
                q_dly_d[s_q] = q_acc_q;
                s_d          = s_q + SW'(1);
                if (s_q == SW'(STAGES - 1)) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                y_i_d      = scale(i_acc_q, shift_lat_q);
                y_q_d      = scale(q_acc_q, shift_lat_q);
                out_tick_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state_q     <= IDLE;
            s_q         <= '0;
            cnt_q       <= '0;
            r_lat_q     <= decim_eff;
            shift_lat_q <= shift;
            i_samp_q    <= '0;
            q_samp_q    <= '0;
            i_acc_q     <= '0;
            q_acc_q     <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                i_dly_q[k] <= '0;
                q_dly_q[k] <= '0;
            end
            y_i_q       <= '0;
            y_q_q       <= '0;
            req_q       <= 1'b0;
            out_tick_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            r_lat_q     <= r_lat_d;
            shift_lat_q <= shift_lat_d;
            i_samp_q    <= i_samp_d;
            q_samp_q    <= q_samp_d;
            i_acc_q     <= i_acc_d;
            q_acc_q     <= q_acc_d;
            i_dly_q     <= i_dly_d;
            q_dly_q     <= q_dly_d;
            y_i_q       <= y_i_d;
            y_q_q       <= y_q_d;
            req_q       <= req_d;
            out_tick_q  <= out_tick_d;
            overrun_q   <= overrun_d;
        end
    end

    assign y_i      = y_i_q;
    assign y_q      = y_q_q;
    assign out_tick = out_tick_q;
    assign overrun  = overrun_q;

endmodule
